// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
// rtl/cnn_layer_accel_weight_seq_ctrl.sv - weight sequence table read controller
//
// Walks table addresses base..last once per pass, for cfg_num_passes+1 passes,
// issuing one read per cycle that adv is high. seq_valid/seq_last follow the
// read enable through a C_RD_LATENCY-deep shift register so they line up with
// the table data.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, abort     begin a sequence (IDLE only) / cancel it (RUN, DRAIN)
//   cfg_base_addr    first address of a pass
//   cfg_last_addr    last address of a pass, inclusive
//   cfg_num_passes   number of passes minus one
//   adv              consumer ready; gates each read
//   rdAddr, rden     registered table read address / enable
//   seq_valid        table output valid, aligned to table data
//   seq_last         final entry of the final pass, aligned to seq_valid
//   busy, done       sequence in progress / one-cycle completion pulse
//   cfg_err          sticky illegal-configuration flag
module cnn_layer_accel_weight_seq_ctrl #(
  parameter int C_NUM_SEQ_VALUES = 64,
  parameter int C_RDADDR_WIDTH   = $clog2(C_NUM_SEQ_VALUES),
  parameter int C_RD_LATENCY     = 1,
  parameter int C_PASS_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [C_RDADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [C_RDADDR_WIDTH-1:0] cfg_last_addr,
  input  logic [C_PASS_WIDTH-1:0]   cfg_num_passes,
  input  logic                      adv,
  output logic [C_RDADDR_WIDTH-1:0] rdAddr,
  output logic                      rden,
  output logic                      seq_valid,
  output logic                      seq_last,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [31:0] LAST_MAX = 32'(C_NUM_SEQ_VALUES - 1);
  localparam logic [2:0]  DRAIN_END = 3'(C_RD_LATENCY);

  state_t                    state, state_nxt;
  logic [C_RDADDR_WIDTH-1:0] base_q, last_q, addr_q;
  logic [C_PASS_WIDTH-1:0]   npass_q, pass_q;
  logic [2:0]                dcnt_q;
  logic                      rlast_q;
  logic [C_RD_LATENCY-1:0]   vpipe_q, lpipe_q;

  logic cfg_ok, issue, at_last, final_rd, drain_end;

  assign cfg_ok    = (cfg_base_addr <= cfg_last_addr) && (32'(cfg_last_addr) <= LAST_MAX);
  // abort outranks adv, so a cancelled cycle never issues a read
  assign issue     = (state == S_RUN) && adv && !abort;
  assign at_last   = (addr_q == last_q);
  assign final_rd  = at_last && (pass_q == npass_q);
  // DRAIN holds until the final entry has emerged from the pipeline, so the
  // DONE cycle falls immediately after the seq_last cycle
  assign drain_end = (dcnt_q == DRAIN_END);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && cfg_ok) state_nxt = S_RUN;
      S_RUN: begin
        if (abort)                  state_nxt = S_IDLE;
        else if (issue && final_rd) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)          state_nxt = S_IDLE;
        else if (drain_end) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy = (state == S_RUN) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // config, counters and read port
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      last_q  <= '0;
      npass_q <= '0;
      addr_q  <= '0;
      pass_q  <= '0;
      rdAddr  <= '0;
      rden    <= 1'b0;
      rlast_q <= 1'b0;
      cfg_err <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      rden    <= 1'b0;
      rlast_q <= 1'b0;
      dcnt_q  <= (state == S_DRAIN) ? dcnt_q + 3'd1 : 3'd0;
      if (state == S_IDLE && start) begin
        if (cfg_ok) begin
          base_q  <= cfg_base_addr;
          last_q  <= cfg_last_addr;
          npass_q <= cfg_num_passes;
          addr_q  <= cfg_base_addr;
          pass_q  <= '0;
          cfg_err <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (issue) begin
        rden    <= 1'b1;
        rdAddr  <= addr_q;
        rlast_q <= final_rd;
        if (at_last) begin
          addr_q <= base_q;
          pass_q <= pass_q + 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  // valid/last delay line matching the table read latency
  always_ff @(posedge clk) begin
    if (rst || (abort && busy)) begin
      vpipe_q <= '0;
      lpipe_q <= '0;
    end else begin
      vpipe_q[0] <= rden;
      lpipe_q[0] <= rlast_q;
      for (int i = 1; i < C_RD_LATENCY; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
        lpipe_q[i] <= lpipe_q[i-1];
      end
    end
  end

  assign seq_valid = vpipe_q[C_RD_LATENCY-1];
  assign seq_last  = lpipe_q[C_RD_LATENCY-1];

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_ctrl.sv
// tb/tb_cnn_layer_accel_weight_seq_ctrl.sv - self-checking bench for the weight sequence controller
module tb_cnn_layer_accel_weight_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, adv;
  logic [5:0]  cfg_base, cfg_last;
  logic [15:0] cfg_np;

  logic [5:0] rdAddr1, rdAddr3;
  logic       rden1, seq_valid1, seq_last1, busy1, done1, cfg_err1;
  logic       rden3, seq_valid3, seq_last3, busy3, done3, cfg_err3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cnn_layer_accel_weight_seq_ctrl #(.C_RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base), .cfg_last_addr(cfg_last), .cfg_num_passes(cfg_np),
    .adv(adv), .rdAddr(rdAddr1), .rden(rden1), .seq_valid(seq_valid1),
    .seq_last(seq_last1), .busy(busy1), .done(done1), .cfg_err(cfg_err1)
  );

  cnn_layer_accel_weight_seq_ctrl #(.C_RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base), .cfg_last_addr(cfg_last), .cfg_num_passes(cfg_np),
    .adv(adv), .rdAddr(rdAddr3), .rden(rden3), .seq_valid(seq_valid3),
    .seq_last(seq_last3), .busy(busy3), .done(done3), .cfg_err(cfg_err3)
  );

  // mode: 0 adv always 1, 1 adv toggles 1,0,..., 2 adv random
  typedef struct {
    int base;
    int last;
    int np;
    int mode;
    int midstart;
    int abst;
    int exp_reads;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int exp_addr[$];
    int nr1 = 0, nr3 = 0, nv1 = 0, nv3 = 0, nl1 = 0, nl3 = 0, nd1 = 0, nd3 = 0;
    int lastc1 = -1, lastc3 = -1, donec1 = -1, donec3 = -1;
    int firstr = -1, lastr = -1;
    int addr_err = 0, hold_err = 0, dly_err = 0, lerr = 0;
    int prev1, prev3, limit;
    logic h1 = 1'b0;
    logic [2:0] h3 = 3'b000;
    string tag;
    tag = $sformatf("v%0d", idx);
    for (int p = 0; p <= v.np; p++)
      for (int a = v.base; a <= v.last; a++) exp_addr.push_back(a);
    prev1 = int'(rdAddr1);
    prev3 = int'(rdAddr3);
    @(negedge clk);
    cfg_base = 6'(v.base);
    cfg_last = 6'(v.last);
    cfg_np   = 16'(v.np);
    start    = 1'b1;
    abort    = (v.abst != 0);
    adv      = 1'b0;
    limit    = 600;
    for (int cyc = 0; cyc < limit; cyc++) begin
      @(negedge clk);
      // drive for the coming edge
      abort = 1'b0;
      if (v.midstart != 0 && cyc == 3) begin
        start = 1'b1; cfg_base = 6'd0; cfg_last = 6'd1; cfg_np = 16'd0;
      end else begin
        start = 1'b0;
      end
      case (v.mode)
        0:       adv = 1'b1;
        1:       adv = (cyc % 2 == 0);
        default: adv = 1'($urandom_range(0, 1));
      endcase
      if (cyc == 0) continue;
      // sample what the previous edge produced
      if (rden1) begin
        if (nr1 >= exp_addr.size() || int'(rdAddr1) != exp_addr[nr1]) addr_err++;
        if (firstr < 0) firstr = cyc;
        lastr = cyc;
        nr1++;
      end else if (int'(rdAddr1) != prev1) hold_err++;
      if (rden3) begin
        if (nr3 >= exp_addr.size() || int'(rdAddr3) != exp_addr[nr3]) addr_err++;
        nr3++;
      end else if (int'(rdAddr3) != prev3) hold_err++;
      prev1 = int'(rdAddr1);
      prev3 = int'(rdAddr3);
      if (seq_valid1 != h1) dly_err++;
      if (seq_valid3 != h3[2]) dly_err++;
      h1 = rden1;
      h3 = {h3[1:0], rden3};
      if (seq_valid1) nv1++;
      if (seq_valid3) nv3++;
      if (seq_last1) begin
        nl1++; lastc1 = cyc;
        if (!seq_valid1 || nv1 != v.exp_reads) lerr++;
      end
      if (seq_last3) begin
        nl3++; lastc3 = cyc;
        if (!seq_valid3 || nv3 != v.exp_reads) lerr++;
      end
      if (done1) begin nd1++; donec1 = cyc; end
      if (done3) begin nd3++; donec3 = cyc; end
      if (nd1 > 0 && nd3 > 0 && limit == 600) limit = cyc + 4;
    end
    adv = 1'b0;
    chk({tag, " reads dut1"}, nr1, v.exp_reads);
    chk({tag, " reads dut3"}, nr3, v.exp_reads);
    chk({tag, " valids dut1"}, nv1, v.exp_reads);
    chk({tag, " valids dut3"}, nv3, v.exp_reads);
    chk({tag, " last count dut1"}, nl1, 1);
    chk({tag, " last count dut3"}, nl3, 1);
    chk({tag, " done count dut1"}, nd1, 1);
    chk({tag, " done count dut3"}, nd3, 1);
    chk({tag, " done after last dut1"}, donec1, lastc1 + 1);
    chk({tag, " done after last dut3"}, donec3, lastc3 + 1);
    chk({tag, " address order"}, addr_err, 0);
    chk({tag, " address hold"}, hold_err, 0);
    chk({tag, " valid delay"}, dly_err, 0);
    chk({tag, " last alignment"}, lerr, 0);
    chk({tag, " idle after"}, int'(busy1 | busy3), 0);
    chk({tag, " cfg_err clear"}, int'(cfg_err1), 0);
    if (v.mode == 0) chk({tag, " back-to-back reads"}, lastr - firstr + 1, v.exp_reads);
  endtask

  initial begin
    int n, bad;
    vecs[0] = '{base: 2,  last: 5,  np: 1, mode: 0, midstart: 0, abst: 0, exp_reads: 8};
    vecs[1] = '{base: 2,  last: 5,  np: 1, mode: 1, midstart: 0, abst: 0, exp_reads: 8};
    vecs[2] = '{base: 7,  last: 7,  np: 3, mode: 0, midstart: 0, abst: 0, exp_reads: 4};
    vecs[3] = '{base: 0,  last: 63, np: 0, mode: 2, midstart: 0, abst: 0, exp_reads: 64};
    vecs[4] = '{base: 10, last: 12, np: 2, mode: 2, midstart: 0, abst: 1, exp_reads: 9};
    vecs[5] = '{base: 2,  last: 5,  np: 1, mode: 0, midstart: 1, abst: 0, exp_reads: 8};

    rst = 1'b1; start = 1'b0; abort = 1'b0; adv = 1'b1;
    cfg_base = 6'd1; cfg_last = 6'd2; cfg_np = 16'd0;
    // start during reset must be ignored
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("reset rdAddr", int'(rdAddr1), 0);
    chk("reset rden", int'(rden1), 0);
    chk("reset seq_valid", int'(seq_valid1 | seq_valid3), 0);
    chk("reset seq_last", int'(seq_last1 | seq_last3), 0);
    chk("reset busy", int'(busy1 | busy3), 0);
    chk("reset done", int'(done1 | done3), 0);
    chk("reset cfg_err", int'(cfg_err1), 0);
    start = 1'b0;
    rst = 1'b0;

    // illegal configuration
    @(negedge clk);
    cfg_base = 6'd9; cfg_last = 6'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("illegal cfg_err", int'(cfg_err1), 1);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy1 || rden1 || busy3 || rden3 || !cfg_err1) bad++;
    end
    chk("illegal stays idle", bad, 0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // abort after the third read
    @(negedge clk);
    cfg_base = 6'd2; cfg_last = 6'd5; cfg_np = 16'd1; start = 1'b1; adv = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (rden3) n++;
    end
    chk("abort reached third read", n, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", int'(busy1 | busy3), 0);
    chk("abort rden", int'(rden1 | rden3), 0);
    bad = 0;
    repeat (8) begin
      if (seq_valid1 || seq_valid3 || seq_last3 || done1 || done3 || rden3) bad++;
      @(negedge clk);
    end
    chk("abort quiet", bad, 0);
    adv = 1'b0;
    run_vec(6, vecs[0]);

    // reset while draining
    @(negedge clk);
    cfg_base = 6'd7; cfg_last = 6'd7; cfg_np = 16'd0; start = 1'b1; adv = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n == 0; c++) begin
      @(negedge clk);
      if (rden1) n++;
    end
    chk("drain reached", int'(busy1 & ~rden1 ? 0 : n), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("drain rst outputs", int'({rdAddr1, rden1, seq_valid1, seq_last1, busy1, done1, cfg_err1}), 0);
    chk("drain rst outputs dut3", int'({rdAddr3, rden3, seq_valid3, seq_last3, busy3, done3, cfg_err3}), 0);
    rst = 1'b0; adv = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done1 || done3 || busy1 || busy3 || seq_valid1 || seq_valid3) bad++;
    end
    chk("drain rst no done", bad, 0);
    run_vec(7, vecs[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
